// File: rtl/unidade_controle_jogo.sv
// Game controller FSM for a memory-sequence game. It paces the LED display,
// collects plays and decides win, loss or timeout.
module unidade_controle_jogo #(
  parameter int LED_CYCLES     = 500,
  parameter int GAP_CYCLES     = 10,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic       jogada_feita,
  input  logic       jogada_correta,
  input  logic       endereco_igual_rodada,
  input  logic       fim_rodadas,
  output logic       zera_e,
  output logic       conta_e,
  output logic       zera_r,
  output logic       conta_r,
  output logic       registra_r,
  output logic       mostra_led,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       db_timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    S_INICIAL     = 4'h0,
    S_PREPARA     = 4'h1,
    S_MOSTRA      = 4'h2,
    S_APAGA       = 4'h3,
    S_PROX_LED    = 4'h4,
    S_ZERA_END    = 4'h5,
    S_ESPERA      = 4'h6,
    S_REGISTRA    = 4'h7,
    S_COMPARA     = 4'h8,
    S_PROX_JOGADA = 4'h9,
    S_PROX_RODADA = 4'hA,
    S_FIM_ACERTO  = 4'hB,
    S_FIM_ERRO    = 4'hC,
    S_FIM_TIMEOUT = 4'hD
  } state_t;

  localparam int DISP_MAX = (LED_CYCLES > GAP_CYCLES) ? LED_CYCLES : GAP_CYCLES;
  localparam int DISP_W   = $clog2(DISP_MAX + 1);
  localparam int ESP_W    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [DISP_W-1:0] LED_LAST = DISP_W'(LED_CYCLES - 1);
  localparam logic [DISP_W-1:0] GAP_LAST = DISP_W'(GAP_CYCLES - 1);
  localparam logic [DISP_W-1:0] DISP_SAT = DISP_W'(DISP_MAX);
  localparam logic [DISP_W-1:0] DISP_ONE = DISP_W'(1);
  localparam logic [ESP_W-1:0]  ESP_LAST = ESP_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ESP_W-1:0]  ESP_SAT  = ESP_W'(TIMEOUT_CYCLES);
  localparam logic [ESP_W-1:0]  ESP_ONE  = ESP_W'(1);

  state_t             state_q, state_d;
  logic [DISP_W-1:0]  tmr_disp_q, tmr_disp_d;
  logic [ESP_W-1:0]   tmr_esp_q, tmr_esp_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_INICIAL;
      tmr_disp_q <= '0;
      tmr_esp_q  <= '0;
    end else begin
      state_q    <= state_d;
      tmr_disp_q <= tmr_disp_d;
      tmr_esp_q  <= tmr_esp_d;
    end
  end

  // NOTE: next state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INICIAL:     if (jogar) state_d = S_PREPARA;
      S_PREPARA:     state_d = S_MOSTRA;
      S_MOSTRA:      if (tmr_disp_q == LED_LAST) state_d = S_APAGA;
      S_APAGA: begin
        if (tmr_disp_q == GAP_LAST)
          state_d = endereco_igual_rodada ? S_ZERA_END : S_PROX_LED;
      end
      S_PROX_LED:    state_d = S_MOSTRA;
      S_ZERA_END:    state_d = S_ESPERA;
      S_ESPERA: begin
        // A play arriving on the last allowed cycle beats the timeout.
        if (jogada_feita)               state_d = S_REGISTRA;
        else if (tmr_esp_q == ESP_LAST) state_d = S_FIM_TIMEOUT;
      end
      S_REGISTRA:    state_d = S_COMPARA;
      S_COMPARA: begin
        if (!jogada_correta)             state_d = S_FIM_ERRO;
        else if (!endereco_igual_rodada) state_d = S_PROX_JOGADA;
        else if (fim_rodadas)            state_d = S_FIM_ACERTO;
        else                             state_d = S_PROX_RODADA;
      end
      S_PROX_JOGADA: state_d = S_ESPERA;
      S_PROX_RODADA: state_d = S_MOSTRA;
      S_FIM_ACERTO,
      S_FIM_ERRO,
      S_FIM_TIMEOUT: if (jogar) state_d = S_PREPARA;
      default:       state_d = S_INICIAL;
    endcase
  end

  // Timers restart on every state entry and saturate instead of wrapping.
  always_comb begin
    tmr_disp_d = '0;
    tmr_esp_d  = '0;
    if (state_d == state_q && (state_q == S_MOSTRA || state_q == S_APAGA))
      tmr_disp_d = (tmr_disp_q == DISP_SAT) ? tmr_disp_q : tmr_disp_q + DISP_ONE;
    if (state_d == state_q && state_q == S_ESPERA)
      tmr_esp_d = (tmr_esp_q == ESP_SAT) ? tmr_esp_q : tmr_esp_q + ESP_ONE;
  end

  always_comb begin
    zera_e     = 1'b0;
    conta_e    = 1'b0;
    zera_r     = 1'b0;
    conta_r    = 1'b0;
    registra_r = 1'b0;
    mostra_led = 1'b0;
    pronto     = 1'b0;
    ganhou     = 1'b0;
    perdeu     = 1'b0;
    db_timeout = 1'b0;
    unique case (state_q)
      S_PREPARA: begin
        zera_e = 1'b1;
        zera_r = 1'b1;
      end
      S_MOSTRA:      mostra_led = 1'b1;
      S_PROX_LED:    conta_e    = 1'b1;
      S_ZERA_END:    zera_e     = 1'b1;
      S_REGISTRA:    registra_r = 1'b1;
      S_PROX_JOGADA: conta_e    = 1'b1;
      S_PROX_RODADA: begin
        conta_r = 1'b1;
        zera_e  = 1'b1;
      end
      S_FIM_ACERTO: begin
        pronto = 1'b1;
        ganhou = 1'b1;
      end
      S_FIM_ERRO: begin
        pronto = 1'b1;
        perdeu = 1'b1;
      end
      S_FIM_TIMEOUT: begin
        pronto     = 1'b1;
        perdeu     = 1'b1;
        db_timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = state_q;

endmodule
